// File: rtl/alu_pkg.sv
// alu_pkg: shared op codes, FSM states and flag helpers
// for the handshaked multi-cycle ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_SLL  = 4'b0011,
    ALU_SRL  = 4'b0100,
    ALU_SLTU = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_MUL  = 4'b1000,
    ALU_NOR  = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Signed overflow from operand/result sign bits only,
  // so it is independent of the datapath width.
  function automatic logic add_ovf(
    input logic sa,
    input logic sb,
    input logic sr,
    input logic sub
  );
    logic sbe;
    sbe = sub ? ~sb : sb;
    return (sa == sbe) && (sr != sa);
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: WIDTH-cycle shift-add multiplier,
// low WIDTH bits of the unsigned product.
module alu_mul_iter
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] p
);

  localparam int SHW = $clog2(WIDTH);

  logic             busy;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] mc;
  logic [WIDTH-1:0] mp;
  logic [WIDTH-1:0] acc;

  // p is the accumulator after the current step, so the
  // caller can capture it on the same edge as the last step.
  assign p    = acc + (mp[0] ? mc : '0);
  assign done = busy && (cnt == SHW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      mc   <= '0;
      mp   <= '0;
      acc  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      mc   <= a;
      mp   <= b;
      acc  <= '0;
    end else if (busy) begin
      acc <= p;
      mc  <= mc << 1;
      mp  <= mp >> 1;
      cnt <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// alu_mc: valid/ready ALU with single-cycle logic/arith ops,
// an iterative multiply and a registered result channel.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic             zero,
  output logic             ovf,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state;
  state_e           nxt;
  logic             fire;
  logic             is_mul;
  logic             mul_done;
  logic [WIDTH-1:0] mul_p;
  logic [WIDTH-1:0] res;
  logic             res_ovf;
  logic             res_err;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] dif;
  logic [SHW-1:0]   sh;

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign fire      = in_valid && in_ready;
  assign is_mul    = (op == ALU_MUL);
  assign sum       = a + b;
  assign dif       = a - b;
  assign sh        = b[SHW-1:0];

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (fire && is_mul),
    .a     (a),
    .b     (b),
    .done  (mul_done),
    .p     (mul_p)
  );

  always_comb begin
    res     = '0;
    res_ovf = 1'b0;
    res_err = 1'b0;
    unique case (op)
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_NOR:  res = ~(a | b);
      ALU_ADD: begin
        res     = sum;
        res_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], sum[WIDTH-1], 1'b0);
      end
      ALU_SUB: begin
        res     = dif;
        res_ovf = add_ovf(a[WIDTH-1], b[WIDTH-1], dif[WIDTH-1], 1'b1);
      end
      ALU_SLL:  res = a << sh;
      ALU_SRL:  res = a >> sh;
      ALU_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(WIDTH-1){1'b0}}, a < b};
      ALU_MUL:  res = '0;
      default:  res_err = 1'b1;
    endcase
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE: if (fire) nxt = is_mul ? MUL : HOLD;
      MUL:  if (mul_done) nxt = HOLD;
      HOLD: begin
        if (fire) nxt = is_mul ? MUL : HOLD;
        else if (out_ready) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r    <= '0;
      zero <= 1'b0;
      ovf  <= 1'b0;
      err  <= 1'b0;
    end else if (fire && !is_mul) begin
      r    <= res;
      zero <= (res == '0);
      ovf  <= res_ovf;
      err  <= res_err;
    end else if (mul_done) begin
      r    <= mul_p;
      zero <= (mul_p == '0);
      ovf  <= 1'b0;
      err  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed vectors for alu_mc at WIDTH=8 with a
// queued scoreboard checked by an independent output monitor.
module tb_alu_mc;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] r;
    logic         z;
    logic         o;
    logic         e;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] r;
  logic         zero;
  logic         ovf;
  logic         err;

  exp_t q[$];
  exp_t mon_e;
  int   errs   = 0;
  int   checks = 0;
  int   wt;
  logic ok;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r         (r),
    .zero      (zero),
    .ovf       (ovf),
    .err       (err)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(
    input logic [W-1:0] rr,
    input logic z,
    input logic o,
    input logic e
  );
    exp_t x;
    x.r = rr;
    x.z = z;
    x.o = o;
    x.e = e;
    return x;
  endfunction

  task automatic check(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] req
  );
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errs++;
        $display("FAIL unexpected_out: got r=%h want none", r);
      end else begin
        mon_e = q.pop_front();
        check("result{r,z,o,e}", {21'd0, r, zero, ovf, err},
              {21'd0, mon_e});
      end
    end
  end

  task automatic issue(
    input  logic [3:0]   o,
    input  logic [W-1:0] ai,
    input  logic [W-1:0] bi,
    input  exp_t         e,
    output int           waits
  );
    logic good;
    in_valid = 1'b1;
    op       = o;
    a        = ai;
    b        = bi;
    waits    = 0;
    @(negedge clk);
    while (!in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    q.push_back(e);
    tick();
    in_valid = 1'b0;
    if (o == 4'b1000) begin
      good = 1'b1;
      for (int j = 0; j < W; j++) begin
        if (j > 0) tick();
        if (out_valid || in_ready) good = 1'b0;
      end
      check("mul_busy", {31'd0, good}, 32'd1);
      tick();
      check("mul_latency", {31'd0, out_valid}, 32'd1);
    end else begin
      check("latency1", {31'd0, out_valid}, 32'd1);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    op        = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_r", {24'd0, r}, 32'd0);
    check("rst_flags", {29'd0, zero, ovf, err}, 32'd0);

    issue(4'b0010, 8'h7F, 8'h01, mk(8'h80, 0, 1, 0), wt);
    issue(4'b0110, 8'h05, 8'h05, mk(8'h00, 1, 0, 0), wt);
    issue(4'b0110, 8'h80, 8'h01, mk(8'h7F, 0, 1, 0), wt);
    issue(4'b0111, 8'hFF, 8'h01, mk(8'h01, 0, 0, 0), wt);
    issue(4'b0101, 8'hFF, 8'h01, mk(8'h00, 1, 0, 0), wt);
    issue(4'b0011, 8'h01, 8'h0B, mk(8'h08, 0, 0, 0), wt);
    issue(4'b0100, 8'h80, 8'h0F, mk(8'h01, 0, 0, 0), wt);
    issue(4'b0000, 8'hF0, 8'h3C, mk(8'h30, 0, 0, 0), wt);
    issue(4'b0001, 8'hF0, 8'h0F, mk(8'hFF, 0, 0, 0), wt);
    issue(4'b1100, 8'h0F, 8'hF0, mk(8'h00, 1, 0, 0), wt);
    issue(4'b1111, 8'h12, 8'h34, mk(8'h00, 1, 0, 1), wt);
    issue(4'b1000, 8'h0D, 8'h0B, mk(8'h8F, 0, 0, 0), wt);

    issue(4'b0010, 8'h01, 8'h02, mk(8'h03, 0, 0, 0), wt);
    check("b2b_wait0", wt, 0);
    issue(4'b0010, 8'h10, 8'h20, mk(8'h30, 0, 0, 0), wt);
    check("b2b_wait1", wt, 0);
    issue(4'b0010, 8'hFF, 8'h01, mk(8'h00, 1, 0, 0), wt);
    check("b2b_wait2", wt, 0);
    repeat (2) tick();

    out_ready = 1'b0;
    issue(4'b0010, 8'h11, 8'h22, mk(8'h33, 0, 0, 0), wt);
    in_valid = 1'b1;
    op       = 4'b0010;
    a        = 8'h01;
    b        = 8'h01;
    ok       = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (r !== 8'h33 || in_ready !== 1'b0 || out_valid !== 1'b1)
        ok = 1'b0;
      tick();
    end
    check("hold_stable", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    #1;
    check("hold_release_ready", {31'd0, in_ready}, 32'd1);
    q.push_back(mk(8'h02, 0, 0, 0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("hold_pending_out", {31'd0, out_valid}, 32'd1);
    repeat (3) tick();

    in_valid = 1'b1;
    op       = 4'b1000;
    a        = 8'h0D;
    b        = 8'h0B;
    @(negedge clk);
    check("mul2_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_r_flags", {20'd0, r, zero, ovf, err, 1'b0}, 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) ok = 1'b0;
      tick();
    end
    check("mrst_no_pulse", {31'd0, ok}, 32'd1);
    issue(4'b0010, 8'h02, 8'h03, mk(8'h05, 0, 0, 0), wt);

    repeat (3) tick();
    check("queue_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
